// File: rtl/fp16_neuron_acc.sv
// fp16_neuron_acc: serial FP16 multiply-accumulate neuron front-end.
// Accepts N_INPUTS (x, w) pairs over valid/ready and forms bias + sum(x*w)
// in half precision with a five-state multi-cycle datapath
// (WAIT -> MUL -> ALIGN -> ADD -> NORM), then holds the result in OUT
// until the downstream sigmoid stage takes it.
// Build option: define FP16_NEURON_RELU_EN to clamp negative results to +0.
// Number handling: zero/denormal inputs act as signed zero, inf/NaN act as
// +-0x7BFF, underflow flushes to +0, overflow saturates, truncation only.
module fp16_neuron_acc #(
  parameter int N_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_w,
  input  logic [15:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_MUL   = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [15:0]        acc;
  logic               accept;
  logic               last_pair;

  // Stage registers (data only, no reset needed)
  logic [15:0]        x_p0, w_p0;
  logic [15:0]        prod_p1;
  logic               a_sign_p2, eff_sub_p2;
  logic [4:0]         a_exp_p2;
  logic [10:0]        a_man_p2, b_man_p2;
  logic               sum_sign_p3;
  logic [4:0]         sum_exp_p3;
  logic [11:0]        sum_mag_p3;

  // Combinational stage results
  logic [15:0]        prod_c;
  logic               a_sign_c, eff_sub_c;
  logic [4:0]         a_exp_c;
  logic [10:0]        a_man_c, b_man_c;
  logic [11:0]        sum_mag_c;
  logic [15:0]        norm_c;

  // Map special encodings onto the finite range: zero/denormal -> signed
  // zero, inf/NaN -> largest finite magnitude with the original sign.
  function automatic logic [15:0] sanitize(input logic [15:0] h);
    if (h[14:10] == 5'd0)       return {h[15], 15'h0000};
    else if (h[14:10] == 5'd31) return {h[15], 15'h7BFF};
    else                        return h;
  endfunction

  // 11-bit significand with the hidden bit; zero operands have none.
  function automatic logic [10:0] man11(input logic [15:0] h);
    if (h[14:10] == 5'd0) return 11'd0;
    else                  return {1'b1, h[9:0]};
  endfunction

  // Assemble a result from a signed biased exponent: flush to +0 on
  // underflow, saturate to the largest finite value on overflow.
  function automatic logic [15:0] pack(input logic sign,
                                       input logic signed [7:0] exp,
                                       input logic [9:0] frac);
    if (exp <= 8'sd0)       return 16'h0000;
    else if (exp >= 8'sd31) return {sign, 15'h7BFF};
    else                    return {sign, exp[4:0], frac};
  endfunction

  // Bring a 12-bit sum back to 1.f form; carry shifts right, otherwise
  // shift left past leading zeros. Dropped bits are simply truncated.
  function automatic logic [15:0] normalize(input logic sign,
                                            input logic [4:0] exp,
                                            input logic [11:0] mag);
    logic signed [7:0] e;
    logic [3:0]        lz;
    logic              found;
    logic [9:0]        frac;
    e     = $signed({3'b000, exp});
    lz    = 4'd0;
    found = 1'b0;
    if (mag == 12'd0) return 16'h0000;
    if (mag[11]) return pack(sign, e + 8'sd1, mag[10:1]);
    for (int i = 10; i >= 0; i--) begin
      if (!found && mag[i]) begin
        lz    = 4'(10 - i);
        found = 1'b1;
      end
    end
    frac = mag[9:0] << lz;
    return pack(sign, e - $signed({4'b0000, lz}), frac);
  endfunction

  // Optional non-negative clamp applied as the result enters OUT.
  function automatic logic [15:0] relu(input logic [15:0] h);
`ifdef FP16_NEURON_RELU_EN
    return h[15] ? 16'h0000 : h;
`else
    return h;
`endif
  endfunction

  assign accept    = (state == S_WAIT) && in_valid;
  assign last_pair = (count == CNT_W'(N_INPUTS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_next;
  end

  // Next-state sequencing and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_MUL;
      end
      S_MUL:   state_next = S_ALIGN;
      S_ALIGN: state_next = S_ADD;
      S_ADD:   state_next = S_NORM;
      S_NORM:  state_next = last_pair ? S_OUT : S_WAIT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_WAIT;
      end
      default: state_next = S_WAIT;
    endcase
  end

  // Frame control: pair counter, accumulator and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      acc     <= 16'h0000;
      out_sum <= 16'h0000;
    end else begin
      if (accept && (count == '0)) acc <= bias;
      if (state == S_NORM) begin
        acc   <= norm_c;
        count <= count + 1'b1;
        if (last_pair) out_sum <= relu(norm_c);
      end
      if ((state == S_OUT) && out_ready) count <= '0;
    end
  end

  // ---- p0: operands captured on acceptance ----
  // Latch the accepted pair
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0 <= in_x;
      w_p0 <= in_w;
    end
  end

  // MUL: product sign, exponent and truncated significand
  always_comb begin
    logic [15:0]       xs, ws;
    logic [21:0]       mprod;
    logic signed [7:0] pexp;
    logic              psign;
    xs     = sanitize(x_p0);
    ws     = sanitize(w_p0);
    psign  = xs[15] ^ ws[15];
    mprod  = 22'(man11(xs)) * 22'(man11(ws));
    pexp   = $signed({3'b000, xs[14:10]}) + $signed({3'b000, ws[14:10]}) - 8'sd15;
    prod_c = 16'h0000;
    if ((xs[14:10] == 5'd0) || (ws[14:10] == 5'd0))
      prod_c = 16'h0000;
    else if (mprod[21])
      prod_c = pack(psign, pexp + 8'sd1, mprod[20:11]);
    else
      prod_c = pack(psign, pexp, mprod[19:10]);
  end

  // ---- p1: product ----
  // Register the product
  always_ff @(posedge clk) begin
    if (state == S_MUL) prod_p1 <= prod_c;
  end

  // ALIGN: larger magnitude becomes A, B's significand shifted to A's exponent
  always_comb begin
    logic [15:0] acc_s, prod_s, op_a, op_b;
    logic [4:0]  shift;
    acc_s     = sanitize(acc);
    prod_s    = sanitize(prod_p1);
    op_a      = acc_s;
    op_b      = prod_s;
    if (prod_s[14:0] > acc_s[14:0]) begin
      op_a = prod_s;
      op_b = acc_s;
    end
    shift     = op_a[14:10] - op_b[14:10];
    a_sign_c  = op_a[15];
    a_exp_c   = op_a[14:10];
    a_man_c   = man11(op_a);
    b_man_c   = (shift >= 5'd11) ? 11'd0 : (man11(op_b) >> shift);
    eff_sub_c = op_a[15] ^ op_b[15];
  end

  // ---- p2: aligned operands ----
  // Register the aligned operands
  always_ff @(posedge clk) begin
    if (state == S_ALIGN) begin
      a_sign_p2  <= a_sign_c;
      a_exp_p2   <= a_exp_c;
      a_man_p2   <= a_man_c;
      b_man_p2   <= b_man_c;
      eff_sub_p2 <= eff_sub_c;
    end
  end

  // ADD: magnitude add or subtract; A >= B so subtraction never goes negative
  always_comb begin
    if (eff_sub_p2) sum_mag_c = {1'b0, a_man_p2} - {1'b0, b_man_p2};
    else            sum_mag_c = {1'b0, a_man_p2} + {1'b0, b_man_p2};
  end

  // ---- p3: raw sum ----
  // Register the raw sum with A's sign and exponent
  always_ff @(posedge clk) begin
    if (state == S_ADD) begin
      sum_sign_p3 <= a_sign_p2;
      sum_exp_p3  <= a_exp_p2;
      sum_mag_p3  <= sum_mag_c;
    end
  end

  // NORM: renormalise into the next accumulator value
  always_comb begin
    norm_c = normalize(sum_sign_p3, sum_exp_p3, sum_mag_p3);
  end

endmodule

// File: tb/tb_fp16_neuron_acc.sv
// Directed bench for fp16_neuron_acc: one N_INPUTS=4 and one N_INPUTS=1
// instance share the clock, reset and operand buses.
module tb_fp16_neuron_acc;

  logic        clk;
  logic        rst_n;
  logic [15:0] x, w, b;
  logic        iv4, ir4, ov4, or4;
  logic        iv1, ir1, ov1, or1;
  logic [15:0] os4, os1;
  int          errors;
  int          checks;
  logic [15:0] held;

  fp16_neuron_acc #(.N_INPUTS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_x(x), .in_w(w), .bias(b),
    .out_valid(ov4), .out_ready(or4), .out_sum(os4)
  );

  fp16_neuron_acc #(.N_INPUTS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_x(x), .in_w(w), .bias(b),
    .out_valid(ov1), .out_ready(or1), .out_sum(os1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one pair once the selected instance is ready; returns 1 ns after the accept edge.
  task automatic send(input bit sel, input logic [15:0] xv, input logic [15:0] wv,
                      input logic [15:0] bv);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? ir1 : ir4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 16'(sel ? ir1 : ir4), 16'd1);
    x = xv; w = wv; b = bv;
    if (sel) iv1 = 1'b1; else iv4 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0; iv4 = 1'b0;
    x = 16'hDEAD; w = 16'hBEEF; b = 16'h1234;
  endtask

  // Wait for the result, compare it, then complete the output handshake.
  task automatic recv(input bit sel, input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(sel ? ov1 : ov4) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 16'(sel ? ov1 : ov4), 16'd1);
    chk({tag, "_sum"}, sel ? os1 : os4, exp);
    if (sel) or1 = 1'b1; else or4 = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_vld_clr"}, 16'(sel ? ov1 : ov4), 16'd0);
    chk({tag, "_rdy_back"}, 16'(sel ? ir1 : ir4), 16'd1);
    or1 = 1'b0; or4 = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0;
    iv4 = 1'b0; iv1 = 1'b0; or4 = 1'b0; or1 = 1'b0;
    x = 16'h0000; w = 16'h0000; b = 16'h0000;

    // Reset values
    #1;
    chk("rst_in_ready4", 16'(ir4), 16'd1);
    chk("rst_out_valid4", 16'(ov4), 16'd0);
    chk("rst_out_sum4", os4, 16'h0000);
    chk("rst_out_sum1", os1, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Case 1: 0 + 4 x (1.0 * 0.5) = 2.0, with latency checks
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    chk("busy_after_accept", 16'(ir4), 16'd0);
    repeat (3) @(posedge clk);
    #1 chk("busy_at_e3", 16'(ir4), 16'd0);
    @(posedge clk);
    #1 chk("ready_at_e4", 16'(ir4), 16'd1);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    chk("ov_low_e0", 16'(ov4), 16'd0);
    repeat (3) @(posedge clk);
    #1 chk("ov_low_e3", 16'(ov4), 16'd0);
    @(posedge clk);
    #1 chk("ov_high_e4", 16'(ov4), 16'd1);
    chk("ir_low_out", 16'(ir4), 16'd0);
    recv(1'b0, 16'h4000, "case1");

    // Cancellation: 1.0 + 1.0*(-1.0) + 3 x 0 = +0
    send(1'b0, 16'h3C00, 16'hBC00, 16'h3C00);
    send(1'b0, 16'h0000, 16'h3C00, 16'h0000);
    send(1'b0, 16'h0000, 16'h3C00, 16'h0000);
    send(1'b0, 16'h0000, 16'h3C00, 16'h0000);
    recv(1'b0, 16'h0000, "cancel");

    // N=1 cases
    send(1'b1, 16'h7800, 16'h4000, 16'h0000);
    recv(1'b1, 16'h7BFF, "saturate");
    send(1'b1, 16'h0000, 16'h3C00, 16'hBC00);
`ifdef FP16_NEURON_RELU_EN
    recv(1'b1, 16'h0000, "relu");
`else
    recv(1'b1, 16'hBC00, "relu");
`endif
    send(1'b1, 16'h3C00, 16'hB800, 16'h4000);
    recv(1'b1, 16'h3E00, "sub_norm");
    send(1'b1, 16'h7C00, 16'h3800, 16'h0000);
    recv(1'b1, 16'h77FF, "inf_input");
    send(1'b1, 16'h0001, 16'h3C00, 16'h3C00);
    recv(1'b1, 16'h3C00, "denorm_input");
    send(1'b1, 16'h0400, 16'h0400, 16'h0000);
    recv(1'b1, 16'h0000, "underflow");

    // Backpressure: 1.0 + 4 x (1.0 * 1.0) = 5.0, held for 10 cycles
    send(1'b0, 16'h3C00, 16'h3C00, 16'h3C00);
    send(1'b0, 16'h3C00, 16'h3C00, 16'h3C00);
    send(1'b0, 16'h3C00, 16'h3C00, 16'h3C00);
    send(1'b0, 16'h3C00, 16'h3C00, 16'h3C00);
    repeat (4) @(posedge clk);
    #1 chk("bp_valid_start", 16'(ov4), 16'd1);
    held = os4;
    chk("bp_sum", held, 16'h4500);
    iv4 = 1'b1; x = 16'h4000; w = 16'h4000; b = 16'h4000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 16'(ov4), 16'd1);
      chk("bp_hold_sum", os4, 16'h4500);
      chk("bp_in_ready", 16'(ir4), 16'd0);
    end
    iv4 = 1'b0;
    recv(1'b0, 16'h4500, "bp");
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    recv(1'b0, 16'h4000, "after_bp");

    // Reset mid-frame after 2 of 4 pairs
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 16'(ir4), 16'd1);
    chk("midrst_out_valid", 16'(ov4), 16'd0);
    chk("midrst_out_sum", os4, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    send(1'b0, 16'h3C00, 16'h3800, 16'h0000);
    recv(1'b0, 16'h4000, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_neuron_acc.md
# fp16_neuron_acc

Serial FP16 multiply-accumulate neuron front-end that sits directly upstream of the FP16 sigmoid stage. It accepts a stream of N (input, weight) pairs over a valid/ready handshake and forms bias + Σ(x·w) in IEEE-754 half precision using a multi-cycle state machine. It presents the sum on a held output with its own valid/ready handshake, in the format the sigmoid stage consumes as its operand `a`.

## Interface
- `N_INPUTS`, default 4: pairs per frame, ≥1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_x`, `in_w` and `bias` are valid.
- `in_ready`  out  1  high only in WAIT.
- `in_x`  in  16  FP16 input activation.
- `in_w`  in  16  FP16 weight.
- `bias`  in  16  FP16 bias, sampled only on acceptance of pair index 0.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  16  FP16 accumulated result.

## Operation
- States: WAIT → MUL → ALIGN → ADD → NORM → (WAIT | OUT).
- WAIT: `in_ready`=1. On `in_valid`, latch `in_x`/`in_w`. If count==0, load the accumulator with `bias`. Go to MUL.
- MUL: sign = xor. Exp = ea+eb−15. Mantissa = {1,ma}·{1,mb}, 22 bits. If bit 21 is set, shift right 1 and exp+1. Truncate to 10 fraction bits.
- ALIGN: order the operands by magnitude (bits 14:0) so A ≥ B. Right-shift B's 11-bit mantissa by ea−eb, truncating the shifted-out bits. A shift ≥11 gives 0.
- ADD: if the signs are equal, add mantissas into a 12-bit result; otherwise A−B. The result sign is A's sign.
- NORM:
  - On carry, shift right 1 and exp+1.
  - Otherwise, left-shift until bit 10 is set, decrementing exp per shift.
  - A zero mantissa gives +0 (0x0000).
  - Write the result to the accumulator.
  - Increment count. If count becomes `N_INPUTS`, go to OUT and load `out_sum`; else go to WAIT.
- OUT: `out_valid`=1, `out_sum` stable. On `out_ready`, set count=0, `out_valid`=0 and go to WAIT.
- Number rules, applied to inputs, product and sum:
  - exp field 0 (zero/denormal) → treated as signed zero.
  - exp field 31 (inf/NaN) → treated as ±0x7BFF.
  - Result biased exp ≤0 → +0.
  - Result biased exp ≥31 → saturate to sign|0x7BFF.
  - No rounding; truncation everywhere.
- Count width is clog2(`N_INPUTS`+1).

## Timing
- Reset values: state WAIT, count 0, accumulator 0x0000, `in_ready`=1, `out_valid`=0, `out_sum`=0x0000.
- Reset asserted mid-frame discards the partial sum immediately. No output is produced for that frame.
- A pair accepted at edge E is folded into the accumulator at edge E+4. `in_ready` is high again after edge E+4, so peak rate is 1 pair per 5 cycles.
- Last pair accepted at edge E gives `out_valid` high after edge E+4.
- `in_valid` while `in_ready`=0 is ignored; input data need not be held.
- While in OUT with `out_ready` low, `out_valid` and `out_sum` hold indefinitely and `in_ready`=0.
- Handshake at edge H gives `in_ready`=1 after H. The earliest next-frame accept is H+1.
- `N_INPUTS`=1: each pair yields one result (bias + x·w).

## Configuration
- `FP16_NEURON_RELU_EN`:
  - Defined: when entering OUT, a negative result (bit 15 = 1) is replaced by 0x0000, so the sigmoid stage only ever receives non-negative operands.
  - Undefined: the signed sum passes through unchanged.

## Test plan
- N=4, bias 0x0000, four pairs (0x3C00, 0x3800): `out_sum`=0x4000 (2.0), with `out_valid` rising 4 edges after the last accept.
- Cancellation, N=4, bias 0x3C00:
  - Stimulus: pair (0x3C00, 0xBC00), then (0x0000, 0x3C00)×3.
  - Required: `out_sum`=0x0000 (+0).
- Saturation, N=1, bias 0x0000, pair (0x7800, 0x4000): product overflows, so `out_sum`=0x7BFF.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `out_valid`/`out_sum` are stable and `in_ready`=0 throughout.
  - After the handshake, the next frame is accepted and computed correctly.
- Reset: pulse `rst_n` low after 2 of 4 pairs.
  - All outputs take their reset values asynchronously.
  - A following full frame from case 1 yields 0x4000.
- RELU, N=1, bias 0xBC00, pair (0x0000, 0x3C00):
  - With `FP16_NEURON_RELU_EN`: `out_sum`=0x0000.
  - Without it: `out_sum`=0xBC00.
